// File: rtl/axi_bw_sched_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : axi_bw_sched_pkg
//  Description : Shared types and constants for the DDR bandwidth scheduler:
//                SoftReg request/response structs, register window offsets,
//                credit scaling and the scheduler FSM state encoding.
//  Revision    : 1.0 - initial release
// ============================================================================
package axi_bw_sched_pkg;

    typedef struct packed {
        logic        valid;
        logic        isWrite;
        logic [31:0] addr;
        logic [63:0] data;
    } SoftRegReq;

    typedef struct packed {
        logic        valid;
        logic [63:0] data;
    } SoftRegResp;

    // Register window layout, relative to the block's SoftReg base address
    localparam int          c_sr_weight_stride = 8;
    localparam logic [31:0] c_sr_off_epoch     = 32'h20;
    localparam logic [31:0] c_sr_off_credit    = 32'h28;

    // Credit granted per unit of weight at each reload is weight << shift
    localparam int          c_credit_shift     = 4;
    localparam logic [7:0]  c_weight_rst       = 8'd16;
    localparam logic [15:0] c_credit_rst       = 16'd256;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT  = 2'd1,
        ST_RELOAD = 2'd2
    } sched_state_e;

endpackage
`default_nettype wire

// File: rtl/axi_bw_sched_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin selector. Returns the first set
//                request at or after the pointer, wrapping N_APP-1 -> 0.
//  Ports       : i_req    - request vector
//                i_ptr    - highest-priority position
//                o_onehot - one-hot winner (zero when no request)
//                o_idx    - winner index
//                o_any    - at least one request set
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int N_APP = 4,
    parameter int IW    = (N_APP > 1) ? $clog2(N_APP) : 1
) (
    input  logic [N_APP-1:0] i_req,
    input  logic [IW-1:0]    i_ptr,
    output logic [N_APP-1:0] o_onehot,
    output logic [IW-1:0]    o_idx,
    output logic             o_any
);
    localparam int PW = IW + 1;

    logic [PW-1:0] w_pos;

    // Walk offsets from farthest to nearest so the nearest hit is the last
    // assignment and therefore wins.
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_any    = 1'b0;
        w_pos    = '0;
        for (int k = N_APP - 1; k >= 0; k--) begin
            w_pos = {1'b0, i_ptr} + PW'(k);
            if (w_pos >= PW'(N_APP)) begin
                w_pos = w_pos - PW'(N_APP);
            end
            if (i_req[w_pos[IW-1:0]]) begin
                o_onehot                 = '0;
                o_onehot[w_pos[IW-1:0]]  = 1'b1;
                o_idx                    = w_pos[IW-1:0];
                o_any                    = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/axi_bw_sched.sv
`default_nettype none
// ============================================================================
//  Module      : axi_bw_sched
//  Description : Credit-based weighted round-robin scheduler for AR/AW bursts
//                of N_APP requesters sharing one DDR path. Credits are
//                reloaded from per-app weights once per epoch.
//  Ports       : clk, rst_n  - clock, synchronous active-low reset
//                sr_req      - SoftReg access (weights, epoch length, credits)
//                sr_resp     - SoftReg read response, one cycle after request
//                req_valid   - per-app pending burst
//                req_len     - per-app AXI len (beats = len+1)
//                grant       - one-hot issue permission
//                grant_ack   - granted burst's address handshake done
//  Revision    : 1.0 - initial release
// ============================================================================
module axi_bw_sched
    import axi_bw_sched_pkg::*;
#(
    parameter int          N_APP     = 4,
    parameter logic [31:0] SR_ADDR   = 32'h40,
    parameter int          EPOCH_RST = 1024
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  SoftRegReq             sr_req,
    output SoftRegResp            sr_resp,
    input  logic [N_APP-1:0]      req_valid,
    input  logic [N_APP-1:0][7:0] req_len,
    output logic [N_APP-1:0]      grant,
    input  logic                  grant_ack
);
    localparam int IW = (N_APP > 1) ? $clog2(N_APP) : 1;

    sched_state_e     r_state;
    sched_state_e     w_state_nxt;
    logic [7:0]       r_weight [N_APP];
    logic [15:0]      r_credit [N_APP];
    logic [15:0]      r_epoch_len;
    logic [15:0]      r_epoch_cnt;
    logic [IW-1:0]    r_rr_ptr;
    logic [IW-1:0]    r_win_idx;
    logic [7:0]       r_win_len;
    logic [N_APP-1:0] r_grant;
    logic             r_reload_pend;
    SoftRegResp       r_resp;

    logic [15:0]      w_len_eff;
    logic             w_wrap;
    logic [N_APP-1:0] w_elig;
    logic [N_APP-1:0] w_pick_onehot;
    logic [IW-1:0]    w_pick_idx;
    logic             w_pick_any;
    logic [N_APP-1:0] w_grant_nxt;
    logic             w_take;
    logic             w_debit;
    logic             w_load;
    logic             w_pend_set;
    logic             w_pend_clr;
    logic             w_rd_hit;
    logic [63:0]      w_rd_data;
    logic [63:0]      w_credit_pack;
    logic             w_unused;

    assign w_unused = ^sr_req.data[63:16];

    // ------------------------------------------------------------------
    // Epoch timing: a length of 0 behaves as 1 (reload every cycle). The
    // >= compare also wraps promptly when the length is shortened below
    // the current count.
    // ------------------------------------------------------------------
    assign w_len_eff = (r_epoch_len == 16'd0) ? 16'd1 : r_epoch_len;
    assign w_wrap    = (r_epoch_cnt >= (w_len_eff - 16'd1));

    // ------------------------------------------------------------------
    // Eligibility and round-robin selection
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < N_APP; g++) begin : g_elig
            assign w_elig[g] = req_valid[g] && (r_weight[g] != 8'd0) &&
                               (r_credit[g] >= ({8'd0, req_len[g]} + 16'd1));
        end
    endgenerate

    rr_pick #(
        .N_APP (N_APP),
        .IW    (IW)
    ) u_rr_pick (
        .i_req    (w_elig),
        .i_ptr    (r_rr_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_any    (w_pick_any)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state. A wrap seen in GRANT is deferred through
    // r_reload_pend so an outstanding grant is never cut; a wrap on the
    // ack cycle itself goes straight to RELOAD after the debit.
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_wrap) begin
                    w_state_nxt = ST_RELOAD;
                end else if (w_pick_any) begin
                    w_state_nxt = ST_GRANT;
                end
            end
            ST_GRANT: begin
                if (grant_ack) begin
                    w_state_nxt = (r_reload_pend || w_wrap) ? ST_RELOAD : ST_IDLE;
                end
            end
            ST_RELOAD: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs (next grant value and datapath strobes)
    // ------------------------------------------------------------------
    always_comb begin
        w_grant_nxt = '0;
        w_take      = 1'b0;
        w_debit     = 1'b0;
        w_load      = 1'b0;
        w_pend_set  = 1'b0;
        w_pend_clr  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_wrap && w_pick_any) begin
                    w_grant_nxt = w_pick_onehot;
                    w_take      = 1'b1;
                end
            end
            ST_GRANT: begin
                if (grant_ack) begin
                    w_debit = 1'b1;
                end else begin
                    w_grant_nxt = r_grant;
                    w_pend_set  = w_wrap;
                end
            end
            ST_RELOAD: begin
                w_load     = 1'b1;
                w_pend_clr = 1'b1;
            end
            default: begin
                w_grant_nxt = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Scheduler datapath and register file
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_grant       <= '0;
            r_rr_ptr      <= '0;
            r_win_idx     <= '0;
            r_win_len     <= '0;
            r_reload_pend <= 1'b0;
            r_epoch_cnt   <= '0;
            r_epoch_len   <= 16'(EPOCH_RST);
            for (int i = 0; i < N_APP; i++) begin
                r_weight[i] <= c_weight_rst;
                r_credit[i] <= c_credit_rst;
            end
        end else begin
            r_grant     <= w_grant_nxt;
            r_epoch_cnt <= w_wrap ? 16'd0 : (r_epoch_cnt + 16'd1);

            // Length is captured at grant time; the debit uses this copy
            if (w_take) begin
                r_win_idx <= w_pick_idx;
                r_win_len <= req_len[w_pick_idx];
            end

            if (w_debit) begin
                r_rr_ptr <= (r_win_idx == IW'(N_APP - 1)) ? '0 : (r_win_idx + 1'b1);
            end

            if (w_pend_clr) begin
                r_reload_pend <= 1'b0;
            end else if (w_pend_set) begin
                r_reload_pend <= 1'b1;
            end

            // Reload overwrites: unused credit does not carry over
            for (int i = 0; i < N_APP; i++) begin
                if (w_load) begin
                    r_credit[i] <= {8'd0, r_weight[i]} << c_credit_shift;
                end else if (w_debit && (r_win_idx == IW'(i))) begin
                    r_credit[i] <= r_credit[i] - ({8'd0, r_win_len} + 16'd1);
                end
            end

            // Weight writes only affect credits at the next reload
            if (sr_req.valid && sr_req.isWrite) begin
                for (int i = 0; i < N_APP; i++) begin
                    if (sr_req.addr == (SR_ADDR + 32'(c_sr_weight_stride * i))) begin
                        r_weight[i] <= sr_req.data[7:0];
                    end
                end
                if (sr_req.addr == (SR_ADDR + c_sr_off_epoch)) begin
                    r_epoch_len <= sr_req.data[15:0];
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // SoftReg read path
    // ------------------------------------------------------------------
    generate
        for (genvar g = 0; g < 4; g++) begin : g_pack
            if (g < N_APP) begin : g_used
                assign w_credit_pack[16*g +: 16] = r_credit[g];
            end else begin : g_empty
                assign w_credit_pack[16*g +: 16] = 16'd0;
            end
        end
    endgenerate

    always_comb begin
        w_rd_hit  = 1'b0;
        w_rd_data = '0;
        if (sr_req.valid && !sr_req.isWrite) begin
            for (int i = 0; i < N_APP; i++) begin
                if (sr_req.addr == (SR_ADDR + 32'(c_sr_weight_stride * i))) begin
                    w_rd_hit  = 1'b1;
                    w_rd_data = {56'd0, r_weight[i]};
                end
            end
            if (sr_req.addr == (SR_ADDR + c_sr_off_epoch)) begin
                w_rd_hit  = 1'b1;
                w_rd_data = {48'd0, r_epoch_len};
            end
            if (sr_req.addr == (SR_ADDR + c_sr_off_credit)) begin
                w_rd_hit  = 1'b1;
                w_rd_data = w_credit_pack;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_resp <= '0;
        end else begin
            r_resp.valid <= w_rd_hit;
            r_resp.data  <= w_rd_data;
        end
    end

    assign grant   = r_grant;
    assign sr_resp = r_resp;

endmodule
`default_nettype wire

// File: tb/tb_axi_bw_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_axi_bw_sched
//  Description : Self-checking bench for axi_bw_sched with a cycle-level
//                reference model built from the scheduling rules.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_axi_bw_sched;
    import axi_bw_sched_pkg::*;

    localparam int          N    = 4;
    localparam logic [31:0] SR   = 32'h40;
    localparam int          ERST = 1024;

    logic                clk = 1'b0;
    logic                rst_n;
    SoftRegReq           sr_req;
    SoftRegResp          sr_resp;
    logic [N-1:0]        req_valid;
    logic [N-1:0][7:0]   req_len;
    logic [N-1:0]        grant;
    logic                grant_ack;

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    axi_bw_sched #(
        .N_APP     (N),
        .SR_ADDR   (SR),
        .EPOCH_RST (ERST)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .sr_req    (sr_req),
        .sr_resp   (sr_resp),
        .req_valid (req_valid),
        .req_len   (req_len),
        .grant     (grant),
        .grant_ack (grant_ack)
    );

    // ------------------------------------------------------------------
    // Reference model: m_gnt is the index holding the grant (-1 = none),
    // m_reload marks the one-cycle reload slot.
    // ------------------------------------------------------------------
    int          m_gnt = -1, m_glen = 0, m_ptr = 0, m_cnt = 0, m_elen = ERST;
    bit          m_reload = 0, m_pend = 0;
    int          m_w [N];
    int          m_c [N];
    bit          m_rv = 0;
    logic [63:0] m_rd = '0;
    int          t_eff, t_i;
    bit          t_wrap, t_rv;
    logic [63:0] t_rd;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_gnt = -1; m_ptr = 0; m_cnt = 0; m_elen = ERST;
            m_reload = 0; m_pend = 0; m_rv = 0;
            for (int i = 0; i < N; i++) begin
                m_w[i] = 16;
                m_c[i] = 256;
            end
        end else begin
            t_rv = 1'b0;
            t_rd = '0;
            if (sr_req.valid && !sr_req.isWrite) begin
                for (int i = 0; i < N; i++)
                    if (sr_req.addr == SR + 32'(8 * i)) begin t_rv = 1; t_rd = 64'(m_w[i]); end
                if (sr_req.addr == SR + 32'h20) begin t_rv = 1; t_rd = 64'(m_elen); end
                if (sr_req.addr == SR + 32'h28) begin
                    t_rv = 1;
                    for (int i = 0; i < N; i++) t_rd[16*i +: 16] = 16'(m_c[i]);
                end
            end
            m_rv = t_rv;
            m_rd = t_rd;

            t_eff  = (m_elen == 0) ? 1 : m_elen;
            t_wrap = (m_cnt >= t_eff - 1);
            m_cnt  = t_wrap ? 0 : m_cnt + 1;

            if (m_reload) begin
                for (int i = 0; i < N; i++) m_c[i] = m_w[i] * 16;
                m_pend   = 0;
                m_reload = 0;
            end else if (m_gnt >= 0) begin
                if (grant_ack) begin
                    m_c[m_gnt] = m_c[m_gnt] - (m_glen + 1);
                    m_ptr      = (m_gnt + 1) % N;
                    m_reload   = m_pend || t_wrap;
                    m_gnt      = -1;
                end else if (t_wrap) begin
                    m_pend = 1;
                end
            end else if (t_wrap) begin
                m_reload = 1;
            end else begin
                for (int k = 0; k < N; k++) begin
                    t_i = (m_ptr + k) % N;
                    if (m_gnt < 0 && req_valid[t_i] && m_w[t_i] != 0 &&
                        m_c[t_i] >= int'(req_len[t_i]) + 1) begin
                        m_gnt  = t_i;
                        m_glen = int'(req_len[t_i]);
                    end
                end
            end

            if (sr_req.valid && sr_req.isWrite) begin
                for (int i = 0; i < N; i++)
                    if (sr_req.addr == SR + 32'(8 * i)) m_w[i] = int'(sr_req.data[7:0]);
                if (sr_req.addr == SR + 32'h20) m_elen = int'(sr_req.data[15:0]);
            end
        end
    end

    function automatic logic [N-1:0] exp_grant();
        logic [N-1:0] v;
        v = '0;
        if (m_gnt >= 0) v[m_gnt] = 1'b1;
        return v;
    endfunction

    // ------------------------------------------------------------------
    // Stimulus helpers (no checking)
    // ------------------------------------------------------------------
    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = '0;
        req_len   = '0;
        grant_ack = 1'b0;
        sr_req    = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic sr_write(input logic [31:0] addr, input logic [63:0] data);
        sr_req.valid   = 1'b1;
        sr_req.isWrite = 1'b1;
        sr_req.addr    = addr;
        sr_req.data    = data;
        @(negedge clk);
        sr_req = '0;
    endtask

    task automatic sr_issue_read(input logic [31:0] addr);
        sr_req.valid   = 1'b1;
        sr_req.isWrite = 1'b0;
        sr_req.addr    = addr;
        sr_req.data    = '0;
    endtask

    // ------------------------------------------------------------------
    // Tests
    // ------------------------------------------------------------------
    task automatic test_reset();
        rst_n     = 1'b0;
        req_valid = '1;
        req_len   = '0;
        grant_ack = 1'b1;
        sr_issue_read(SR + 32'h28);
        repeat (3) begin
            @(negedge clk);
            n_checks++;
            if (grant !== '0 || sr_resp.valid !== 1'b0) begin
                n_errors++;
                $display("FAIL reset_outputs: grant=%b valid=%b expected grant=0000 valid=0", grant, sr_resp.valid);
            end
        end
        rst_n     = 1'b1;
        req_valid = '0;
        grant_ack = 1'b0;
        sr_req    = '0;
        @(negedge clk);
        n_checks++;
        if (grant !== '0 || sr_resp.valid !== 1'b0) begin
            n_errors++;
            $display("FAIL reset_release: grant=%b valid=%b expected 0", grant, sr_resp.valid);
        end
    endtask

    task automatic test_sr_read();
        sr_issue_read(SR + 32'h28);
        @(negedge clk);
        n_checks++;
        if (sr_resp.valid !== 1'b1 || sr_resp.data !== 64'h0100_0100_0100_0100) begin
            n_errors++;
            $display("FAIL credit_read_reset: valid=%b data=%h expected 1 %h", sr_resp.valid, sr_resp.data, 64'h0100_0100_0100_0100);
        end
        sr_issue_read(SR + 32'h30);
        @(negedge clk);
        sr_req = '0;
        n_checks++;
        if (sr_resp.valid !== 1'b0) begin
            n_errors++;
            $display("FAIL unmapped_read: valid=%b expected 0", sr_resp.valid);
        end
        sr_issue_read(SR + 32'h20);
        @(negedge clk);
        n_checks++;
        if (sr_resp.valid !== 1'b1 || sr_resp.data !== 64'd1024) begin
            n_errors++;
            $display("FAIL epoch_read: valid=%b data=%h expected 1 %h", sr_resp.valid, sr_resp.data, 64'd1024);
        end
        sr_issue_read(SR + 32'h08);
        @(negedge clk);
        sr_req = '0;
        n_checks++;
        if (sr_resp.valid !== 1'b1 || sr_resp.data !== 64'd16) begin
            n_errors++;
            $display("FAIL weight_read: valid=%b data=%h expected 1 %h", sr_resp.valid, sr_resp.data, 64'd16);
        end
    endtask

    task automatic test_single();
        int ng;
        bit seen;
        req_len   = {N{8'd15}};
        req_valid = 4'b0001;
        @(negedge clk);
        n_checks++;
        if (grant !== 4'b0001) begin
            n_errors++;
            $display("FAIL single_first_grant: grant=%b expected 0001", grant);
        end
        grant_ack = 1'b1;
        req_valid = '0;
        @(negedge clk);
        grant_ack = 1'b0;
        n_checks++;
        if (grant !== 4'b0000) begin
            n_errors++;
            $display("FAIL single_grant_drop: grant=%b expected 0000", grant);
        end
        sr_issue_read(SR + 32'h28);
        @(negedge clk);
        sr_req = '0;
        n_checks++;
        if (sr_resp.valid !== 1'b1 || sr_resp.data !== 64'h0100_0100_0100_00F0) begin
            n_errors++;
            $display("FAIL single_credit_240: data=%h expected %h", sr_resp.data, 64'h0100_0100_0100_00F0);
        end
        req_valid = 4'b0001;
        ng = 0;
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            n_checks++;
            if (grant !== exp_grant()) begin
                n_errors++;
                $display("FAIL single_model c=%0d: grant=%b expected %b", c, grant, exp_grant());
            end
            if (grant[0]) ng++;
            grant_ack = grant[0];
        end
        n_checks++;
        if (ng != 15) begin
            n_errors++;
            $display("FAIL single_burst_count: grants=%0d expected 15", ng);
        end
        grant_ack = 1'b0;
        sr_write(SR + 32'h20, 64'd8);
        seen = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            n_checks++;
            if (grant !== exp_grant()) begin
                n_errors++;
                $display("FAIL single_reload_model c=%0d: grant=%b expected %b", c, grant, exp_grant());
            end
            if (grant[0]) seen = 1;
            grant_ack = grant[0];
        end
        n_checks++;
        if (!seen) begin
            n_errors++;
            $display("FAIL single_regrant_after_reload: seen=0 expected 1");
        end
        grant_ack = 1'b0;
        req_valid = '0;
    endtask

    task automatic test_rotation();
        logic [3:0] seq [5];
        logic [3:0] rot_exp [5];
        int         ts [5];
        int         ng;
        rot_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        do_reset();
        req_len   = '0;
        req_valid = '1;
        ng = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            n_checks++;
            if (grant !== exp_grant()) begin
                n_errors++;
                $display("FAIL rotation_model c=%0d: grant=%b expected %b", c, grant, exp_grant());
            end
            if (grant != '0 && ng < 5) begin
                seq[ng] = grant;
                ts[ng]  = c;
                ng++;
            end
            grant_ack = |grant;
        end
        grant_ack = 1'b0;
        req_valid = '0;
        n_checks++;
        if (ng != 5) begin
            n_errors++;
            $display("FAIL rotation_count: grants=%0d expected 5", ng);
        end else begin
            for (int i = 0; i < 5; i++) begin
                n_checks++;
                if (seq[i] !== rot_exp[i]) begin
                    n_errors++;
                    $display("FAIL rotation_order[%0d]: grant=%b expected %b", i, seq[i], rot_exp[i]);
                end
            end
            for (int i = 1; i < 5; i++) begin
                n_checks++;
                if (ts[i] - ts[i-1] != 2) begin
                    n_errors++;
                    $display("FAIL rotation_spacing[%0d]: gap=%0d expected 2", i, ts[i] - ts[i-1]);
                end
            end
        end
    endtask

    task automatic test_weight_zero();
        int cnt [N];
        do_reset();
        for (int i = 0; i < N; i++) cnt[i] = 0;
        sr_write(SR + 32'h10, 64'd0);
        sr_write(SR + 32'h20, 64'd24);
        req_valid = '1;
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            n_checks++;
            if (grant !== exp_grant()) begin
                n_errors++;
                $display("FAIL wzero_model c=%0d: grant=%b expected %b", c, grant, exp_grant());
            end
            for (int i = 0; i < N; i++) if (grant[i]) cnt[i]++;
            grant_ack = |grant;
            for (int i = 0; i < N; i++) req_len[i] = 8'($urandom_range(0, 15));
        end
        grant_ack = 1'b0;
        req_valid = '0;
        n_checks++;
        if (cnt[2] != 0) begin
            n_errors++;
            $display("FAIL wzero_app2: grants=%0d expected 0", cnt[2]);
        end
        n_checks++;
        if (cnt[0] == 0 || cnt[1] == 0 || cnt[3] == 0) begin
            n_errors++;
            $display("FAIL wzero_others: grants=%0d/%0d/%0d expected all nonzero", cnt[0], cnt[1], cnt[3]);
        end
    endtask

    task automatic test_hold_no_ack();
        bit got;
        do_reset();
        sr_write(SR + 32'h20, 64'd8);
        req_len   = '0;
        req_valid = 4'b0001;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (grant == 4'b0001) got = 1;
        end
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL hold_wait_grant: grant=%b expected 0001 within 20 cycles", grant);
        end
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            n_checks++;
            if (grant !== 4'b0001) begin
                n_errors++;
                $display("FAIL hold_stable c=%0d: grant=%b expected 0001", c, grant);
            end
        end
        grant_ack = 1'b1;
        req_valid = '0;
        @(negedge clk);
        grant_ack = 1'b0;
        n_checks++;
        if (grant !== 4'b0000) begin
            n_errors++;
            $display("FAIL hold_after_ack: grant=%b expected 0000", grant);
        end
        // Read sampled on the reload edge sees the debited value
        sr_issue_read(SR + 32'h28);
        @(negedge clk);
        n_checks++;
        if (sr_resp.data !== 64'h0100_0100_0100_00FF) begin
            n_errors++;
            $display("FAIL hold_debit: data=%h expected %h", sr_resp.data, 64'h0100_0100_0100_00FF);
        end
        @(negedge clk);
        sr_req = '0;
        n_checks++;
        if (sr_resp.valid !== 1'b1 || sr_resp.data !== 64'h0100_0100_0100_0100) begin
            n_errors++;
            $display("FAIL hold_reloaded: data=%h expected %h", sr_resp.data, 64'h0100_0100_0100_0100);
        end
    endtask

    task automatic test_reset_in_grant();
        bit got;
        do_reset();
        req_len   = {N{8'd3}};
        req_valid = 4'b0001;
        got = 0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge clk);
            if (grant == 4'b0001) got = 1;
        end
        n_checks++;
        if (!got) begin
            n_errors++;
            $display("FAIL rstg_wait_grant: grant=%b expected 0001 within 20 cycles", grant);
        end
        @(negedge clk);
        rst_n     = 1'b0;
        grant_ack = 1'b1;
        @(negedge clk);
        n_checks++;
        if (grant !== 4'b0000) begin
            n_errors++;
            $display("FAIL rstg_grant_drop: grant=%b expected 0000", grant);
        end
        rst_n     = 1'b1;
        grant_ack = 1'b0;
        req_valid = '0;
        sr_issue_read(SR + 32'h28);
        @(negedge clk);
        sr_req = '0;
        n_checks++;
        if (sr_resp.valid !== 1'b1 || sr_resp.data !== 64'h0100_0100_0100_0100) begin
            n_errors++;
            $display("FAIL rstg_credits: data=%h expected %h", sr_resp.data, 64'h0100_0100_0100_0100);
        end
    endtask

    task automatic test_random();
        int r;
        do_reset();
        for (int c = 0; c < 2000; c++) begin
            @(negedge clk);
            n_checks++;
            if (grant !== exp_grant() || !$onehot0(grant)) begin
                n_errors++;
                $display("FAIL random_grant c=%0d: grant=%b expected %b", c, grant, exp_grant());
            end
            n_checks++;
            if (sr_resp.valid !== m_rv || (m_rv && sr_resp.data !== m_rd)) begin
                n_errors++;
                $display("FAIL random_resp c=%0d: valid=%b data=%h expected %b %h", c, sr_resp.valid, sr_resp.data, m_rv, m_rd);
            end
            req_valid = 4'($urandom);
            for (int i = 0; i < N; i++) req_len[i] = 8'($urandom_range(0, 15));
            grant_ack = (|grant) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 7) == 0);
            r = $urandom_range(0, 9);
            sr_req = '0;
            if (r == 0) begin
                sr_req.valid   = 1'b1;
                sr_req.isWrite = 1'b1;
                sr_req.addr    = SR + 32'(8 * $urandom_range(0, 5));
                sr_req.data    = 64'($urandom_range(0, 3)) | 64'h0000_0000_0000_2000;
                if (sr_req.addr == SR + 32'h20) sr_req.data = 64'($urandom_range(0, 40));
            end else if (r <= 3) begin
                sr_req.valid   = 1'b1;
                sr_req.isWrite = 1'b0;
                sr_req.addr    = SR + 32'(8 * $urandom_range(0, 6));
            end
        end
        sr_req    = '0;
        req_valid = '0;
        grant_ack = 1'b0;
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = '0;
        req_len   = '0;
        grant_ack = 1'b0;
        sr_req    = '0;
        test_reset();
        test_sr_read();
        test_single();
        test_rotation();
        test_weight_zero();
        test_hold_no_ack();
        test_reset_in_grant();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/axi_bw_sched.md
AXI_BW_SCHED -- requirements
Module: axi_bw_sched

Interface
REQ-001 Parameter N_APP, default 4: number of application requesters sharing the physical DDR path.
REQ-002 Parameter SR_ADDR, default 'h40: SoftReg base address of this block's register window.
REQ-003 Parameter EPOCH_RST, default 1024: reset value of the epoch length in cycles.
REQ-004 clk  input  1: single clock; all logic is synchronous to its rising edge.
REQ-005 rst_n  input  1: synchronous, active-low reset.
REQ-006 sr_req  input  SoftRegReq: register access carrying valid, isWrite, addr and data fields.
REQ-007 sr_resp  output  SoftRegResp: read response carrying valid and data fields.
REQ-008 req_valid  input  N_APP: per-app pending AR/AW burst from the app's axi_buf output.
REQ-009 req_len  input  N_APP x 8: AXI len of each pending burst; beats = len+1.
REQ-010 grant  output  N_APP: one-hot issue permission; gates the winner's AR/AW valid into the translation path.
REQ-011 grant_ack  input  1: granted burst's address handshake completed this cycle.

Function
REQ-012 Per-app 8-bit weight registers live at SR_ADDR+8*i; epoch length (16-bit) is at SR_ADDR+'h20; packed credits (4x16, read-only) are at SR_ADDR+'h28.
REQ-013 SoftReg writes to mapped addresses take effect on the next cycle; writes to unmapped addresses are ignored.
REQ-014 A mapped read returns sr_resp.valid=1 exactly one cycle after sr_req, with zero-extended data.
REQ-015 Unmapped reads produce no response.
REQ-016 Each app holds a 16-bit credit counter; reload sets credit[i] = weight[i]<<4, overwriting the old value with no carry-over.
REQ-017 App i is eligible when req_valid[i]=1, weight[i]!=0 and credit[i] >= req_len[i]+1.
REQ-018 The FSM has states IDLE, GRANT and RELOAD.
REQ-019 IDLE: if any app is eligible, select the first eligible app at or after rr_ptr (round-robin, wrapping N_APP-1 -> 0), register grant one-hot, and go to GRANT; latency is req_valid to grant = 1 cycle.
REQ-020 GRANT: grant is held stable until grant_ack.
REQ-021 On grant_ack: credit[winner] -= len+1 (using len sampled at grant); rr_ptr = winner+1 mod N_APP; grant is deasserted next cycle; the FSM goes to IDLE, or to RELOAD if reload_pend is set.
REQ-022 The minimum spacing between successive grants is 2 cycles.
REQ-023 The epoch counter increments every cycle; on reaching epoch_len-1 it wraps to 0 and requests a reload.
REQ-024 Reload request in IDLE: go to RELOAD.
REQ-025 Reload request in GRANT: set reload_pend; the reload must never cut an outstanding grant.
REQ-026 RELOAD lasts one cycle: load all credits, clear reload_pend, return to IDLE; grant stays 0 in this state.
REQ-027 epoch_len=0 is treated as 1, giving a reload every cycle.
REQ-028 An app with weight 0 is never granted; a request with insufficient credit waits for the next reload.
REQ-029 A weight write mid-epoch does not alter the current credit; it applies at the next reload.
REQ-030 Simultaneous grant_ack and epoch wrap: the debit is applied first, then the FSM enters RELOAD on the following cycle.
REQ-031 grant_ack while not in GRANT is ignored.
REQ-032 grant is always one-hot or zero.

Reset
REQ-033 While rst_n=0, on the clock edge: state=IDLE, grant=0, sr_resp.valid=0, rr_ptr=0, epoch counter=0, reload_pend=0, weight[i]=16, credit[i]=256, epoch_len=EPOCH_RST.
REQ-034 Reset asserted during GRANT drops grant on the next edge with no credit debit.

Structure
REQ-035 Register offsets, the credit shift (4) and the FSM state enum belong in the shared AOS package.
REQ-036 The round-robin priority selector is a sub-module named rr_pick (N_APP-wide request plus pointer in, one-hot plus index out, combinational).

Verification
REQ-037 After reset, req_valid=4'b0001, len=15: grant=0001 at t+1; after ack, credit[0]=240; after 16 such bursts, no grant until reload.
REQ-038 All four apps request continuously, len=0, acks immediate: grants rotate 0001,0010,0100,1000,0001 with one idle cycle between grants.
REQ-039 Weight write 0 to app 2, then epoch wrap: app 2 is never granted afterwards, and the other apps are unaffected.
REQ-040 epoch_len=8, grant held 20 cycles without ack: no reload during GRANT; RELOAD occurs the cycle after ack; credits are restored.
REQ-041 SoftReg read of SR_ADDR+'h28 after reset returns 0x0100_0100_0100_0100 one cycle later; a read of 'h30 returns nothing.
REQ-042 rst_n low during GRANT: grant=0 next cycle; credits=256.
